// File: rtl/reg_bus_perf_endpoint.sv
// Register-bus responder for one tile component: CTRL, SCRATCH, ID, STATUS
// and N_CNT 64-bit event counters read through a shared MSB snapshot.
// Reads are answered two edges after the request with a one-cycle rvalid pulse.
module reg_bus_perf_endpoint #(
    parameter int COMP_ID = 0,
    parameter int N_CNT   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             reg_bus_wvalid,
    input  logic [15:0]      reg_bus_waddr,
    input  logic [31:0]      reg_bus_wdata,
    input  logic             reg_bus_arvalid,
    input  logic [15:0]      reg_bus_araddr,
    output logic             reg_bus_rvalid,
    output logic [31:0]      reg_bus_rdata,
    input  logic [N_CNT-1:0] event_in,
    output logic             cnt_enable
);

    localparam logic [7:0]  ADDR_CTRL    = 8'h00;
    localparam logic [7:0]  ADDR_SCRATCH = 8'h04;
    localparam logic [7:0]  ADDR_ID      = 8'h08;
    localparam logic [7:0]  ADDR_STATUS  = 8'h0C;
    localparam logic [7:0]  ADDR_CNT0    = 8'h10;
    localparam logic [31:0] RD_UNMAPPED  = 32'hDEAD_BEEF;

    logic              count_en;
    logic [31:0]       scratch;
    logic [31:0]       shadow_msb;
    logic [63:0]       cnt_all [N_CNT];
    logic [N_CNT-1:0]  ovf;

    logic [7:0]  wa;
    logic [7:0]  ra;
    logic        wr_ctrl;
    logic        wr_scratch;
    logic        wr_status;
    logic        clear;

    assign wa         = reg_bus_waddr[7:0];
    assign ra         = reg_bus_araddr[7:0];
    assign wr_ctrl    = reg_bus_wvalid && (wa == ADDR_CTRL);
    assign wr_scratch = reg_bus_wvalid && (wa == ADDR_SCRATCH);
    assign wr_status  = reg_bus_wvalid && (wa == ADDR_STATUS);
    assign clear      = wr_ctrl && reg_bus_wdata[1];

    // Counter window: 0x10 + 8*i is the LSB word, 0x14 + 8*i the MSB snapshot.
    logic [7:0]  roff;
    logic [4:0]  ridx;
    logic        cnt_hit;
    logic [63:0] cnt_sel;

    assign roff    = ra - ADDR_CNT0;
    assign ridx    = roff[7:3];
    assign cnt_hit = (ra >= ADDR_CNT0) && (ra[1:0] == 2'b00) && (32'(ridx) < N_CNT);

    // Pick the addressed counter without indexing past the array.
    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < N_CNT; i++) begin
            if (ridx == 5'(i)) cnt_sel = cnt_all[i];
        end
    end

    // Read data from current (pre-write, pre-increment) state.
    logic [31:0] rd_next;
    logic        load_shadow;

    always_comb begin
        rd_next     = RD_UNMAPPED;
        load_shadow = 1'b0;
        case (ra)
            ADDR_CTRL:    rd_next = {31'd0, count_en};
            ADDR_SCRATCH: rd_next = scratch;
            ADDR_ID:      rd_next = {24'h0, 8'(COMP_ID)};
            ADDR_STATUS:  rd_next = 32'(ovf);
            default: begin
                if (cnt_hit) begin
                    if (!ra[2]) begin
                        rd_next     = cnt_sel[31:0];
                        load_shadow = reg_bus_arvalid;
                    end else begin
                        rd_next = shadow_msb;
                    end
                end
            end
        endcase
    end

    // Two-stage read pipeline; rd_hold is zero when no request is in flight.
    logic        rd_pend;
    logic [31:0] rd_hold;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pend        <= 1'b0;
            rd_hold        <= '0;
            reg_bus_rvalid <= 1'b0;
            reg_bus_rdata  <= '0;
        end else begin
            rd_pend        <= reg_bus_arvalid;
            rd_hold        <= reg_bus_arvalid ? rd_next : 32'd0;
            reg_bus_rvalid <= rd_pend;
            reg_bus_rdata  <= rd_hold;
        end
    end

    // Writable control state and the shared MSB snapshot; clear beats a snapshot load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_en   <= 1'b0;
            scratch    <= '0;
            shadow_msb <= '0;
        end else begin
            if (wr_ctrl)    count_en <= reg_bus_wdata[0];
            if (wr_scratch) scratch  <= reg_bus_wdata;
            if (clear)            shadow_msb <= '0;
            else if (load_shadow) shadow_msb <= cnt_sel[63:32];
        end
    end

    for (genvar i = 0; i < N_CNT; i++) begin : gen_cnt
        logic [63:0] cnt_q;
        logic        ovf_q;
        logic        inc;

        assign inc = count_en && event_in[i] && !clear;

        // Counter with sticky wrap flag; a wrap in the same cycle as a STATUS write keeps the flag set.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (clear)    cnt_q <= '0;
                else if (inc) cnt_q <= cnt_q + 64'd1;
                if (inc && (&cnt_q)) ovf_q <= 1'b1;
                else if (wr_status)  ovf_q <= 1'b0;
            end
        end

        assign cnt_all[i] = cnt_q;
        assign ovf[i]     = ovf_q;
    end

    assign cnt_enable = count_en;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{reg_bus_waddr[15:8], reg_bus_araddr[15:8], roff[2:0]};

endmodule

// File: tb/tb_reg_bus_perf_endpoint.sv
// Directed bench for reg_bus_perf_endpoint (COMP_ID=5, N_CNT=4).
module tb_reg_bus_perf_endpoint;

    localparam int N_CNT = 4;

    logic             clk;
    logic             rstn;
    logic             reg_bus_wvalid;
    logic [15:0]      reg_bus_waddr;
    logic [31:0]      reg_bus_wdata;
    logic             reg_bus_arvalid;
    logic [15:0]      reg_bus_araddr;
    logic             reg_bus_rvalid;
    logic [31:0]      reg_bus_rdata;
    logic [N_CNT-1:0] event_in;
    logic             cnt_enable;

    int n_checks = 0;
    int n_errors = 0;

    reg_bus_perf_endpoint #(.COMP_ID(5), .N_CNT(N_CNT)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .reg_bus_wvalid  (reg_bus_wvalid),
        .reg_bus_waddr   (reg_bus_waddr),
        .reg_bus_wdata   (reg_bus_wdata),
        .reg_bus_arvalid (reg_bus_arvalid),
        .reg_bus_araddr  (reg_bus_araddr),
        .reg_bus_rvalid  (reg_bus_rvalid),
        .reg_bus_rdata   (reg_bus_rdata),
        .event_in        (event_in),
        .cnt_enable      (cnt_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_bus_wvalid = 1'b1;
        reg_bus_waddr  = a;
        reg_bus_wdata  = d;
        @(negedge clk);
        reg_bus_wvalid = 1'b0;
    endtask

    // Request at edge T; rvalid must be low after T, high after T+1, low after T+2.
    task automatic do_read(input string name, input logic [15:0] a, input logic [31:0] exp);
        logic v1, v2, v3;
        logic [31:0] d, d3;
        @(negedge clk);
        reg_bus_arvalid = 1'b1;
        reg_bus_araddr  = a;
        @(negedge clk);
        reg_bus_arvalid = 1'b0;
        v1 = reg_bus_rvalid;
        @(negedge clk);
        v2 = reg_bus_rvalid;
        d  = reg_bus_rdata;
        @(negedge clk);
        v3 = reg_bus_rvalid;
        d3 = reg_bus_rdata;
        check({name, " rvalid pulse"}, {29'd0, v1, v2, v3}, 32'b010);
        check({name, " rdata"}, d, exp);
        check({name, " rdata idle"}, d3, 32'd0);
    endtask

    task automatic force_cnt(input int idx, input logic [63:0] val);
        @(negedge clk);
        case (idx)
            0: force dut.gen_cnt[0].cnt_q = val;
            2: force dut.gen_cnt[2].cnt_q = val;
            3: force dut.gen_cnt[3].cnt_q = val;
            default: force dut.gen_cnt[1].cnt_q = val;
        endcase
        @(negedge clk);
        case (idx)
            0: release dut.gen_cnt[0].cnt_q;
            2: release dut.gen_cnt[2].cnt_q;
            3: release dut.gen_cnt[3].cnt_q;
            default: release dut.gen_cnt[1].cnt_q;
        endcase
    endtask

    initial begin
        logic v_a, v_b, v_c;
        logic [31:0] d_a, d_b;
        bit seen;

        vecs[0]  = '{1'b0, 16'h0008, 32'h0,         32'h0000_0005};
        vecs[1]  = '{1'b0, 16'h0000, 32'h0,         32'h0000_0000};
        vecs[2]  = '{1'b0, 16'h000C, 32'h0,         32'h0000_0000};
        vecs[3]  = '{1'b0, 16'h0010, 32'h0,         32'h0000_0000};
        vecs[4]  = '{1'b1, 16'h0004, 32'hA5A5_1234, 32'h0};
        vecs[5]  = '{1'b0, 16'h0004, 32'h0,         32'hA5A5_1234};
        vecs[6]  = '{1'b1, 16'h0008, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b0, 16'h0008, 32'h0,         32'h0000_0005};
        vecs[8]  = '{1'b0, 16'h0080, 32'h0,         32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 16'h0030, 32'h0,         32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 16'h0002, 32'h0,         32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 16'hFF04, 32'h0,         32'hA5A5_1234};

        rstn = 1'b0;
        reg_bus_wvalid = 1'b0;
        reg_bus_waddr = '0;
        reg_bus_wdata = '0;
        reg_bus_arvalid = 1'b0;
        reg_bus_araddr = '0;
        event_in = '0;
        repeat (3) @(negedge clk);
        check("reset rvalid", {31'd0, reg_bus_rvalid}, 32'd0);
        check("reset rdata", reg_bus_rdata, 32'd0);
        check("reset cnt_enable", {31'd0, cnt_enable}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Simultaneous write and read of SCRATCH returns the old value.
        @(negedge clk);
        reg_bus_wvalid = 1'b1; reg_bus_waddr = 16'h0004; reg_bus_wdata = 32'h1111_1111;
        reg_bus_arvalid = 1'b1; reg_bus_araddr = 16'h0004;
        @(negedge clk);
        reg_bus_wvalid = 1'b0; reg_bus_arvalid = 1'b0;
        @(negedge clk);
        check("wr+rd same cycle", reg_bus_rdata, 32'hA5A5_1234);
        do_read("scratch new", 16'h0004, 32'h1111_1111);

        // Back-to-back reads give back-to-back pulses in order.
        @(negedge clk);
        reg_bus_arvalid = 1'b1; reg_bus_araddr = 16'h0004;
        @(negedge clk);
        reg_bus_araddr = 16'h0008;
        @(negedge clk);
        reg_bus_arvalid = 1'b0;
        v_a = reg_bus_rvalid; d_a = reg_bus_rdata;
        @(negedge clk);
        v_b = reg_bus_rvalid; d_b = reg_bus_rdata;
        @(negedge clk);
        v_c = reg_bus_rvalid;
        check("b2b rvalid", {29'd0, v_a, v_b, v_c}, 32'b110);
        check("b2b first", d_a, 32'h1111_1111);
        check("b2b second", d_b, 32'h0000_0005);

        // Counting gated by count_en.
        do_write(16'h0000, 32'h1);
        check("cnt_enable on", {31'd0, cnt_enable}, 32'd1);
        @(negedge clk); event_in = 4'b0010;
        repeat (10) @(negedge clk);
        event_in = '0;
        do_write(16'h0000, 32'h0);
        check("cnt_enable off", {31'd0, cnt_enable}, 32'd0);
        @(negedge clk); event_in = 4'b0010;
        repeat (3) @(negedge clk);
        event_in = '0;
        do_read("cnt1 lsb", 16'h0018, 32'd10);
        do_read("cnt1 msb", 16'h001C, 32'd0);
        do_read("cnt0 lsb", 16'h0010, 32'd0);

        // Wrap of counter 2 sets STATUS[2]; write clears it.
        force_cnt(2, 64'hFFFF_FFFF_FFFF_FFFE);
        do_write(16'h0000, 32'h1);
        @(negedge clk); event_in = 4'b0100;
        repeat (3) @(negedge clk);
        event_in = '0;
        do_write(16'h0000, 32'h0);
        do_read("cnt2 lsb wrap", 16'h0020, 32'd1);
        do_read("cnt2 msb wrap", 16'h0024, 32'd0);
        do_read("status wrap", 16'h000C, 32'h4);
        do_write(16'h000C, 32'h0);
        do_read("status cleared", 16'h000C, 32'h0);

        // Wrap coincident with STATUS write: the set wins.
        force_cnt(3, 64'hFFFF_FFFF_FFFF_FFFF);
        do_write(16'h0000, 32'h1);
        @(negedge clk);
        event_in = 4'b1000;
        reg_bus_wvalid = 1'b1; reg_bus_waddr = 16'h000C; reg_bus_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        event_in = '0; reg_bus_wvalid = 1'b0;
        do_read("status set wins", 16'h000C, 32'h8);
        do_write(16'h0000, 32'h0);

        // LSB read snapshots the pre-increment MSB.
        force_cnt(0, 64'h0000_0001_FFFF_FFFF);
        do_write(16'h0000, 32'h1);
        @(negedge clk);
        reg_bus_arvalid = 1'b1; reg_bus_araddr = 16'h0010; event_in = 4'b0001;
        @(negedge clk);
        reg_bus_arvalid = 1'b0; event_in = '0;
        @(negedge clk);
        check("snap lsb", reg_bus_rdata, 32'hFFFF_FFFF);
        do_read("snap msb", 16'h0014, 32'h1);

        // Clear with a same-cycle event; count_en follows the written bit0.
        @(negedge clk);
        reg_bus_wvalid = 1'b1; reg_bus_waddr = 16'h0000; reg_bus_wdata = 32'h3; event_in = 4'b0001;
        @(negedge clk);
        reg_bus_wvalid = 1'b0; event_in = '0;
        check("clear cnt_enable", {31'd0, cnt_enable}, 32'd1);
        do_read("clear shadow", 16'h0014, 32'h0);
        do_read("clear cnt0", 16'h0010, 32'h0);
        do_read("ctrl after clear", 16'h0000, 32'h1);

        // Reset while a read is in flight drops the response.
        do_write(16'h0004, 32'h5555_AAAA);
        @(negedge clk);
        reg_bus_arvalid = 1'b1; reg_bus_araddr = 16'h0004;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        reg_bus_arvalid = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (reg_bus_rvalid) seen = 1'b1;
        end
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (reg_bus_rvalid) seen = 1'b1;
        end
        check("reset drops read", {31'd0, seen}, 32'd0);
        check("reset cnt_enable 2", {31'd0, cnt_enable}, 32'd0);
        do_read("post-reset ctrl", 16'h0000, 32'h0);
        do_read("post-reset scratch", 16'h0004, 32'h0);
        do_read("post-reset status", 16'h000C, 32'h0);
        do_read("post-reset shadow", 16'h0014, 32'h0);
        do_read("post-reset cnt1", 16'h0018, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_bus_perf_endpoint.md
Name: reg_bus_perf_endpoint

Overview:
- Component-side responder for the tile register bus. It decodes one component's slice of the host-driven write and read strobes and returns a single-cycle read response.
- It holds a control register, a scratch register, a read-only ID and N_CNT 64-bit event counters with atomic MSB snapshot.
- Every tile component (cores, coalescer, splitter) instantiates it to expose performance counters to the host.

Parameters:
- COMP_ID, 0, component index; returned by the ID register, low 8 bits.
- N_CNT, 4, number of event counters; legal range 1..8.

Ports:
- clk  input  1  clock
- rstn  input  1  reset; asynchronous, active-low
- reg_bus_wvalid  input  1  write strobe for this component (one bit of the tile vector)
- reg_bus_waddr  input  16  write address; only [7:0] decoded
- reg_bus_wdata  input  32  write data
- reg_bus_arvalid  input  1  read strobe for this component
- reg_bus_araddr  input  16  read address; only [7:0] decoded
- reg_bus_rvalid  output  1  read response valid, one-cycle pulse
- reg_bus_rdata  output  32  read response data
- event_in  input  N_CNT  per-counter increment pulses, one count per cycle high
- cnt_enable  output  1  CTRL.bit0, for component-side gating

Behaviour:
- Register map, byte offsets in addr[7:0]:
  - 0x00 CTRL (rw): bit0 count_en; bit1 clear, write-only, self-clearing, reads 0.
  - 0x04 SCRATCH (rw, 32 bits).
  - 0x08 ID (ro): {24'h0, COMP_ID[7:0]}.
  - 0x0C STATUS (ro): bit i = sticky overflow of counter i. A write of any value clears all bits.
  - 0x10+8*i CNT_LSB[i] (ro): returns cnt[i][31:0] and, in the same cycle, loads shadow_msb <= cnt[i][63:32].
  - 0x14+8*i CNT_MSB[i] (ro): returns shadow_msb. A single shadow register is shared by all counters.
- Reads of unmapped addresses, or of counter index >= N_CNT, return 32'hDEADBEEF.
- Writes to read-only or unmapped addresses are ignored.
- Reset values: CTRL=0, SCRATCH=0, all counters=0, STATUS=0, shadow_msb=0, reg_bus_rvalid=0, reg_bus_rdata=0, cnt_enable=0.
- Write timing: the write takes effect at the clk edge where reg_bus_wvalid=1. There is no write acknowledge; the bus master produces the B response itself.
- Read timing: reg_bus_arvalid=1 at edge T gives reg_bus_rvalid=1 for exactly one cycle after edge T+1, with rdata registered.
  - rdata is 0 whenever rvalid=0.
  - Back-to-back arvalid on consecutive cycles gives back-to-back rvalid pulses, one per request, in order.
- Counters:
  - When count_en=1 and event_in[i]=1, cnt[i] <= cnt[i]+1.
  - Wrap from 2^64-1 to 0 sets STATUS[i]; the bit stays set until written.
  - When count_en=0, counters hold.
- Clear: a write of CTRL with bit1=1 zeroes all counters and shadow_msb at that edge.
  - Clear wins over any same-cycle event.
  - CTRL.bit0 takes the written value in the same write.
- Simultaneous write and read in the same cycle:
  - Both are processed.
  - The read returns the pre-write value of the target register.
  - For counters, the read returns the pre-increment value.
- Same-cycle overflow and STATUS write: the set wins.
- Reset asserted mid-operation: all state clears asynchronously. Any pending read response is dropped and rvalid stays 0 after reset is released.

Test Plan:
- Reset, then read 0x08 with COMP_ID=5 -> rvalid exactly one cycle, 1 cycle after arvalid; rdata=0x00000005. Read 0x00 -> 0.
- Write 0x04=0xA5A5_1234, read 0x04 -> 0xA5A51234. Write 0x08=0xFFFF_FFFF, read 0x08 -> unchanged ID. Read 0x80 -> 0xDEADBEEF.
- Write CTRL=1, pulse event_in[1] for 10 cycles, write CTRL=0, pulse 3 more times -> read 0x18 = 10, then 0x1C = 0. Counter 0 reads 0.
- Force cnt[2]=0xFFFF_FFFF_FFFF_FFFE, count_en=1, 3 events -> read 0x20 = 1, read 0x24 = 0, STATUS = 0x4. Write STATUS -> STATUS=0.
- Force cnt[0]=0x0000_0001_FFFF_FFFF, read 0x10 while an event arrives the same cycle -> LSB=0xFFFFFFFF; subsequent read of 0x14 = 1 (snapshot, not 2). Write CTRL=3 with event_in[0]=1 -> cnt[0]=0, count_en=1.
- Issue arvalid, assert rstn=0 the next cycle -> rvalid never asserts. After release, all registers read their reset values.
